// File: rtl/mash_nc_param.sv
// mash_nc_param: MASH 1-1-...-1 delta-sigma modulator with P_STAGES cascaded
// accumulators. The active order can be changed at run time. An on-chip
// noise-cancellation network turns the per-stage carries into one signed
// divider offset.
// Optional build macro: MASH_DITHER_EN adds LFSR dither as a carry-in to the
// last active stage. When it is undefined the output is exactly periodic.
module mash_nc_param #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_STAGES     = 3
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic                      i_load,
  input  logic [2:0]                i_order,
  input  logic [P_DATA_WIDTH-1:0]   i_data,
  input  logic [P_DATA_WIDTH-1:0]   i_seed,
  output logic [P_STAGES-1:0]       o_carry,
  output logic signed [P_STAGES:0]  o_out,
  output logic                      o_valid
);

  localparam int N = P_DATA_WIDTH;
  localparam int W = P_STAGES + 1;

  // Accumulator, carry and history state.
  // hist_q[0] is the stage-1 history, which is also the output register.
  logic [N-1:0]        acc_q  [P_STAGES];
  logic [N-1:0]        acc_d  [P_STAGES];
  logic [P_STAGES-1:0] c_q, c_d;
  logic signed [W-1:0] hist_q [P_STAGES];
  logic signed [W-1:0] hist_d [P_STAGES];
  logic                primed_q, primed_d;
  logic                valid_q, valid_d;

  // Combinational helpers.
  logic [2:0]          order_eff;
  logic [P_STAGES-1:0] active;
  logic [P_STAGES-1:0] last;
  logic [P_STAGES-1:0] cin;
  logic [N:0]          sum [P_STAGES];
  logic [N-1:0]        chain_in;
  logic signed [W-1:0] s [P_STAGES];
  logic signed [W-1:0] s_above, h_above;

  // Clamp the requested order to 1..P_STAGES and derive the per-stage masks.
  always_comb begin
    if (i_order == 3'd0) begin
      order_eff = 3'd1;
    end else if (i_order > 3'(P_STAGES)) begin
      order_eff = 3'(P_STAGES);
    end else begin
      order_eff = i_order;
    end
    active = '0;
    last   = '0;
    for (int i = 0; i < P_STAGES; i++) begin
      active[i] = (i < int'(order_eff));
      last[i]   = ((i + 1) == int'(order_eff));
    end
  end

`ifdef MASH_DITHER_EN
  // Dither LFSR, x^16+x^14+x^13+x^11+1. It restarts from its seed on a load.
  logic [15:0] lfsr_q, lfsr_d;
  logic        lfsr_fb;

  // Next LFSR value: it advances only on enabled cycles.
  always_comb begin
    lfsr_fb = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    lfsr_d  = lfsr_q;
    if (i_load) begin
      lfsr_d = 16'hACE1;
    end else if (i_en) begin
      lfsr_d = {lfsr_fb, lfsr_q[15:1]};
    end
  end

  // LFSR register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  // The dither bit enters only at the last active stage.
  always_comb begin
    cin = last & {P_STAGES{lfsr_q[0]}};
  end
`else
  // Without dither there is no carry-in, so the output is exactly periodic.
  always_comb begin
    cin = '0;
  end
`endif

  // Accumulator chain. Each stage adds the wrapped sum of the stage before it
  // in the same cycle, so the carries of all stages line up in time.
  always_comb begin
    chain_in = i_data;
    for (int i = 0; i < P_STAGES; i++) begin
      sum[i]   = {1'b0, acc_q[i]} + {1'b0, chain_in} + {{N{1'b0}}, cin[i]};
      chain_in = sum[i][N-1:0];
    end
  end

  // Noise cancellation on the registered carries, computed from the last
  // stage down: s_k = c_k + s_{k+1} - previous s_{k+1}.
  // Inactive stages produce 0, so their history is cleared when it is stored.
  always_comb begin
    s_above = '0;
    h_above = '0;
    for (int i = P_STAGES - 1; i >= 0; i--) begin
      if (!active[i]) begin
        s[i] = '0;
      end else if (last[i]) begin
        s[i] = W'(c_q[i]);
      end else begin
        s[i] = W'(c_q[i]) + s_above - h_above;
      end
      s_above = s[i];
      h_above = hist_q[i];
    end
  end

  // Next state. A load takes priority over the enable, and with the enable
  // low every register holds its value.
  always_comb begin
    acc_d    = acc_q;
    c_d      = c_q;
    hist_d   = hist_q;
    primed_d = primed_q;
    valid_d  = 1'b0;
    if (i_load) begin
      for (int i = 0; i < P_STAGES; i++) begin
        acc_d[i]  = '0;
        hist_d[i] = '0;
      end
      acc_d[0] = i_seed;
      c_d      = '0;
      primed_d = 1'b0;
    end else if (i_en) begin
      for (int i = 0; i < P_STAGES; i++) begin
        acc_d[i]  = active[i] ? sum[i][N-1:0] : '0;
        c_d[i]    = active[i] & sum[i][N];
        hist_d[i] = s[i];
      end
      primed_d = 1'b1;
      valid_d  = primed_q;
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < P_STAGES; i++) begin
        acc_q[i]  <= '0;
        hist_q[i] <= '0;
      end
      c_q      <= '0;
      primed_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      hist_q   <= hist_d;
      c_q      <= c_d;
      primed_q <= primed_d;
      valid_q  <= valid_d;
    end
  end

  assign o_carry = c_q;
  assign o_out   = hist_q[0];
  assign o_valid = valid_q;

endmodule

// File: tb/tb_mash_nc_param.sv
// Testbench for mash_nc_param (default build, dither off).
// The reference model tracks the carries and forms the output as
// sum_k Delta^(k-1) c_k, using binomial weights over the carry history.
module tb_mash_nc_param;

  localparam int N = 8;
  localparam int P = 3;
  localparam int W = P + 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         load;
  logic [2:0]   order;
  logic [N-1:0] data;
  logic [N-1:0] seed;
  logic [P-1:0] carry;
  logic [W-1:0] out;
  logic         valid;

  mash_nc_param #(.P_DATA_WIDTH(N), .P_STAGES(P)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_en    (en),
    .i_load  (load),
    .i_order (order),
    .i_data  (data),
    .i_seed  (seed),
    .o_carry (carry),
    .o_out   (out),
    .o_valid (valid)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  int acc_m [P];
  int ch_m  [P][4];   // ch_m[k][j]: carry of stage k, j enabled samples ago
  int out_m;
  bit valid_m;
  bit primed_m;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int binom(input int n, input int k);
    int r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  function automatic int eff_order(input logic [2:0] o);
    if (o == 0) return 1;
    if (int'(o) > P) return P;
    return int'(o);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < P; k++) begin
      acc_m[k] = 0;
      for (int j = 0; j < 4; j++) ch_m[k][j] = 0;
    end
    out_m    = 0;
    valid_m  = 1'b0;
    primed_m = 1'b0;
  endtask

  task automatic model_edge();
    int m, y, x, t, c;
    if (load) begin
      model_reset();
      acc_m[0] = int'(seed);
    end else if (en) begin
      m = eff_order(order);
      y = 0;
      for (int k = 0; k < m; k++)
        for (int j = 0; j <= k; j++)
          y += ((j % 2 == 0) ? 1 : -1) * binom(k, j) * ch_m[k][j];
      out_m = y;
      x = int'(data);
      for (int k = 0; k < P; k++) begin
        if (k < m) begin
          t        = acc_m[k] + x;
          acc_m[k] = t % (1 << N);
          c        = t >> N;
          x        = acc_m[k];
        end else begin
          acc_m[k] = 0;
          c        = 0;
        end
        for (int j = 3; j > 0; j--) ch_m[k][j] = ch_m[k][j-1];
        ch_m[k][0] = c;
      end
      valid_m  = primed_m;
      primed_m = 1'b1;
    end else begin
      valid_m = 1'b0;
    end
  endtask

  task automatic compare_all();
    int cv = 0;
    for (int k = 0; k < P; k++) cv |= ch_m[k][0] << k;
    check("o_out",   int'($signed(out)), out_m);
    check("o_carry", int'(carry), cv);
    check("o_valid", int'(valid), int'(valid_m));
  endtask

  // One clock cycle: advance the model at the edge, compare at the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_load(input logic [2:0] o, input logic [N-1:0] d, input logic [N-1:0] sd);
    order = o; data = d; seed = sd; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  int exp1 [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
  int expc [5] = '{1, 0, 0, 0, 1};
  int seq_out [8];
  int seq_val [8];
  int nz, sum, mn, mx, cnt, guard, snap_out, snap_car;

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; order = 3'd1; data = '0; seed = '0;
    model_reset();
    repeat (3) step();
    check("reset_out",   int'(out), 0);
    check("reset_valid", int'(valid), 0);
    rst = 1'b0;
    $display("phase reset: checks=%0d errors=%0d", checks, errors);

    // Order 1, data 64: the output repeats 0,0,0,1 and is valid from the 2nd edge.
    order = 3'd1; data = 8'd64; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      seq_out[i] = int'($signed(out));
      seq_val[i] = int'(valid);
    end
    for (int i = 0; i < 8; i++) check($sformatf("ord1_seq[%0d]", i), seq_out[i], exp1[i]);
    check("ord1_valid_edge1", seq_val[0], 0);
    check("ord1_valid_edge2", seq_val[1], 1);
    $display("phase order1 data64: checks=%0d errors=%0d", checks, errors);

    // Load with seed 200 mid-run: the first enabled edge after it carries.
    do_load(3'd1, 8'd64, 8'd200);
    check("load_valid_after", int'(valid), 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("load_carry[%0d]", i), int'(carry[0]), expc[i]);
    end
    $display("phase load seed200: checks=%0d errors=%0d", checks, errors);

    // Order 3, data 0: the output and the carries stay at zero.
    do_load(3'd3, 8'd0, 8'd0);
    nz = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (out != 0 || carry != 0) nz++;
    end
    check("zero_run_nonzero", nz, 0);
    $display("phase order3 data0: checks=%0d errors=%0d", checks, errors);

    // Order 3, data 128: 1024 valid samples with mean 1/2 and bounded range.
    do_load(3'd3, 8'd128, 8'd0);
    sum = 0; mn = 100; mx = -100; cnt = 0; guard = 0;
    while (cnt < 1024 && guard < 1100) begin
      step();
      guard++;
      if (valid) begin
        sum += int'($signed(out));
        if (int'($signed(out)) < mn) mn = int'($signed(out));
        if (int'($signed(out)) > mx) mx = int'($signed(out));
        cnt++;
      end
    end
    check("ord3_sample_count", cnt, 1024);
    check_range("ord3_sum128", sum, 508, 516);
    check_range("ord3_min", mn, -3, 4);
    check_range("ord3_max", mx, -3, 4);
    $display("phase order3 data128: sum=%0d min=%0d max=%0d checks=%0d errors=%0d",
             sum, mn, mx, checks, errors);

    // Enable held low for 10 cycles: everything holds and the output is not valid.
    do_load(3'd3, 8'd100, 8'd0);
    repeat (30) step();
    snap_out = int'(out); snap_car = int'(carry);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("hold_out",   int'(out), snap_out);
      check("hold_carry", int'(carry), snap_car);
      check("hold_valid", int'(valid), 0);
    end
    en = 1'b1;
    repeat (30) step();
    $display("phase enable hold: checks=%0d errors=%0d", checks, errors);

    // Order clamping and wrap-around.
    do_load(3'd7, 8'd255, 8'd0);
    repeat (40) step();
    do_load(3'd0, 8'd37, 8'd0);
    repeat (40) step();
    do_load(3'd2, 8'd200, 8'd55);
    repeat (40) step();
    $display("phase order clamp/wrap: checks=%0d errors=%0d", checks, errors);

    // Asynchronous reset in the middle of a cycle.
    do_load(3'd3, 8'd77, 8'd0);
    repeat (12) step();
    @(posedge clk);
    model_edge();
    #2 rst = 1'b1;
    #1;
    check("async_rst_out",   int'(out), 0);
    check("async_rst_carry", int'(carry), 0);
    check("async_rst_valid", int'(valid), 0);
    model_reset();
    @(negedge clk);
    compare_all();
    rst = 1'b0;
    repeat (20) step();
    $display("phase async reset: checks=%0d errors=%0d", checks, errors);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
